// File: rtl/scene_sequencer_pkg.sv
// Shared types and constants for the demo-scene playback controller.
package scene_pkg;

    typedef enum logic {
        GAP,
        PLAY
    } scene_fsm_t;

    localparam logic [1:0] SCENE_BLANK = 2'd0;
    localparam logic [1:0] SCENE_FIRST = 2'd1;
    localparam logic [1:0] SCENE_LAST  = 2'd3;

    localparam int FRAME_CNT_W = 10;

    // Scene order is 1 -> 2 -> 3 -> 1 ...; code 0 is reserved for blank.
    function automatic logic [1:0] next_scene_code(input logic [1:0] s);
        return (s == SCENE_LAST) ? SCENE_FIRST : s + 2'd1;
    endfunction

endpackage

// File: rtl/scene_sequencer_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, registered
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // A new level is accepted only after it has differed from the current
    // accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable     <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 != stable) begin
            if (stable_cnt == CNT_LAST) begin
                stable     <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d  <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            stable_d  <= stable;
            btn_pulse <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// Demo-scene playback controller: frame-counted scenes 1..3 separated by blank
// gaps. Optional debounced skip button is built only when SCENE_SKIP_EN is defined.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int FRAMES_PER_SCENE = 240,
    parameter int GAP_FRAMES       = 8,
    parameter int DEBOUNCE_CYCLES  = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       hold,
    input  logic       skip_btn,
    output logic [1:0] vga_state,
    output logic [1:0] audio_select,
    output logic       frame_tick,
    output logic       gap_active
);

    localparam logic [FRAME_CNT_W-1:0] GAP_LAST  = FRAME_CNT_W'(GAP_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] PLAY_LAST = FRAME_CNT_W'(FRAMES_PER_SCENE - 1);

    scene_fsm_t             state;
    scene_fsm_t             next_state;
    logic [1:0]             scene;
    logic [1:0]             next_scene;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [FRAME_CNT_W-1:0] next_cnt;
    logic                   vsync_q;
    logic                   skip_pulse;
    logic                   count_en;

`ifdef SCENE_SKIP_EN
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_skip_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (skip_btn),
        .btn_pulse(skip_pulse)
    );
`else
    localparam int DEBOUNCE_CYCLES_UNUSED = DEBOUNCE_CYCLES;
    logic skip_btn_unused;
    assign skip_btn_unused = skip_btn;
    assign skip_pulse      = 1'b0;
`endif

    // Falling edge of the active-low vsync marks the start of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync_q & ~vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GAP;
            scene     <= SCENE_FIRST;
            frame_cnt <= '0;
        end else begin
            state     <= next_state;
            scene     <= next_scene;
            frame_cnt <= next_cnt;
        end
    end

    // Skip and final tick share one transition term, so a coincident pair
    // advances the scene only once; hold blocks both.
    always_comb begin
        next_state = state;
        next_scene = scene;
        next_cnt   = frame_cnt;
        count_en   = frame_tick && !hold;
        case (state)
            GAP: begin
                if (count_en && frame_cnt == GAP_LAST) begin
                    next_state = PLAY;
                    next_cnt   = '0;
                end else if (count_en) begin
                    next_cnt = frame_cnt + 1'b1;
                end
            end
            PLAY: begin
                if (!hold && (skip_pulse || (frame_tick && frame_cnt == PLAY_LAST))) begin
                    next_state = GAP;
                    next_scene = next_scene_code(scene);
                    next_cnt   = '0;
                end else if (count_en) begin
                    next_cnt = frame_cnt + 1'b1;
                end
            end
            default: begin
                next_state = GAP;
                next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        vga_state    = SCENE_BLANK;
        audio_select = SCENE_BLANK;
        gap_active   = 1'b1;
        if (state == PLAY) begin
            vga_state    = scene;
            audio_select = scene;
            gap_active   = 1'b0;
        end
    end

endmodule
